// File: rtl/swap_sched_pkg.sv
// Shared types and constants for the swap scheduler.
// Optional statistics counter is enabled with SWAP_SCHED_STATS_EN.
package swap_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SWAP = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int     TOTAL_W   = 32;
  localparam state_t RST_STATE = IDLE;
  localparam logic   RST_FLAG  = 1'b0;

endpackage

// File: rtl/swap_pair.sv
// Two-register swap datapath: parallel load, or simultaneous exchange of A and B.
module swap_pair #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic             swap_en,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_o <= '0;
      b_o <= '0;
    end else if (load_en) begin
      a_o <= a_i;
      b_o <= b_i;
    end else if (swap_en) begin
      a_o <= b_o;
      b_o <= a_o;
    end
  end

endmodule

// File: rtl/swap_sched.sv
// Swap scheduler: accepts operands and a count, runs that many exchanges, presents the pair.
// Define SWAP_SCHED_STATS_EN to add the saturating swap_total counter port.
module swap_sched
  import swap_sched_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [CNT_W-1:0]   cnt_i,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   a_o,
  output logic [WIDTH-1:0]   b_o,
  output logic               out_aborted,
  output logic [CNT_W-1:0]   swap_cnt,
  output logic               busy,
`ifdef SWAP_SCHED_STATS_EN
  output logic [TOTAL_W-1:0] swap_total,
`endif
  output state_t             state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends combinationally on ready, and the producer holds its data until then.

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remaining_q;
  logic             load_fire;
  logic             swap_en;

  assign load_fire = load_valid && (state_q == IDLE);
  // Abort takes priority over the exchange, including the final one.
  assign swap_en   = (state_q == SWAP) && !abort;
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RST_STATE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (load_fire) state_d = (cnt_i == '0) ? DONE : SWAP;
      SWAP: if (abort || remaining_q == CNT_W'(1)) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      IDLE:    load_ready = 1'b1;
      SWAP:    busy       = 1'b1;
      DONE:    out_valid  = 1'b1;
      default: load_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q <= '0;
      swap_cnt    <= '0;
      out_aborted <= RST_FLAG;
    end else if (load_fire) begin
      remaining_q <= cnt_i;
      swap_cnt    <= '0;
      out_aborted <= 1'b0;
    end else if (state_q == SWAP) begin
      if (abort) begin
        out_aborted <= 1'b1;
      end else begin
        remaining_q <= remaining_q - CNT_W'(1);
        swap_cnt    <= swap_cnt + CNT_W'(1);
      end
    end
  end

`ifdef SWAP_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             swap_total <= '0;
    else if (swap_en && swap_total != '1)   swap_total <= swap_total + TOTAL_W'(1);
  end
`endif

  swap_pair #(.WIDTH(WIDTH)) u_pair (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_en (load_fire),
    .swap_en (swap_en),
    .a_i     (a_i),
    .b_i     (b_i),
    .a_o     (a_o),
    .b_o     (b_o)
  );

endmodule

// File: tb/tb_swap_sched.sv
// Directed table-driven bench for swap_sched, plus reset, backpressure and mid-swap reset sequences.
module tb_swap_sched;
  import swap_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [0:0] a_i = '0;
  logic [0:0] b_i = '0;
  logic [3:0] cnt_i = '0;
  logic       abort = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [0:0] a_o;
  logic [0:0] b_o;
  logic       out_aborted;
  logic [3:0] swap_cnt;
  logic       busy;
  state_t     state_dbg;
`ifdef SWAP_SCHED_STATS_EN
  logic [31:0] swap_total;
`endif

  swap_sched #(.WIDTH(1), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .a_i         (a_i),
    .b_i         (b_i),
    .cnt_i       (cnt_i),
    .abort       (abort),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .a_o         (a_o),
    .b_o         (b_o),
    .out_aborted (out_aborted),
    .swap_cnt    (swap_cnt),
    .busy        (busy),
`ifdef SWAP_SCHED_STATS_EN
    .swap_total  (swap_total),
`endif
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       a;
    logic       b;
    logic [3:0] cnt;
    int         abort_at;  // exchanges completed before abort is raised; -1 = never
    logic       exp_a;
    logic       exp_b;
    logic [3:0] exp_cnt;
    logic       exp_ab;
    int         exp_lat;   // edges from accept to out_valid
  } vec_t;

  vec_t vecs[11];
  int   n_vec = 0;
  int   n_miss = 0;
  int   exp_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered and left 1 time unit after a rising edge with the DUT idle.
  task automatic run_vec(input vec_t v, input int idx);
    int cycles;
    check($sformatf("v%0d load_ready", idx), 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    a_i = v.a;
    b_i = v.b;
    cnt_i = v.cnt;
    tick();
    load_valid = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      abort = (cycles == v.abort_at);
      tick();
      cycles++;
    end
    abort = 1'b0;
    check($sformatf("v%0d latency", idx), 32'(cycles), 32'(v.exp_lat));
    check($sformatf("v%0d a_o", idx), 32'(a_o), 32'(v.exp_a));
    check($sformatf("v%0d b_o", idx), 32'(b_o), 32'(v.exp_b));
    check($sformatf("v%0d swap_cnt", idx), 32'(swap_cnt), 32'(v.exp_cnt));
    check($sformatf("v%0d out_aborted", idx), 32'(out_aborted), 32'(v.exp_ab));
    check($sformatf("v%0d busy", idx), 32'(busy), 32'd0);
    check($sformatf("v%0d load_ready_done", idx), 32'(load_ready), 32'd0);
    exp_total += int'(v.exp_cnt);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check($sformatf("v%0d post_valid", idx), 32'(out_valid), 32'd0);
    check($sformatf("v%0d post_ready", idx), 32'(load_ready), 32'd1);
    check($sformatf("v%0d post_a", idx), 32'(a_o), 32'(v.exp_a));
    check($sformatf("v%0d post_cnt", idx), 32'(swap_cnt), 32'(v.exp_cnt));
  endtask

  initial begin
    //            a     b     cnt   abort a     b     ecnt  ab    lat
    vecs[0]  = '{1'b1, 1'b0, 4'd3,  -1,  1'b0, 1'b1, 4'd3,  1'b0, 3};
    vecs[1]  = '{1'b1, 1'b0, 4'd4,  -1,  1'b1, 1'b0, 4'd4,  1'b0, 4};
    vecs[2]  = '{1'b1, 1'b0, 4'd0,  -1,  1'b1, 1'b0, 4'd0,  1'b0, 0};
    vecs[3]  = '{1'b1, 1'b0, 4'd5,   2,  1'b1, 1'b0, 4'd2,  1'b1, 3};
    vecs[4]  = '{1'b0, 1'b1, 4'd3,   2,  1'b0, 1'b1, 4'd2,  1'b1, 3};
    vecs[5]  = '{1'b1, 1'b1, 4'd1,  -1,  1'b1, 1'b1, 4'd1,  1'b0, 1};
    vecs[6]  = '{1'b0, 1'b1, 4'd15, -1,  1'b1, 1'b0, 4'd15, 1'b0, 15};
    vecs[7]  = '{1'b1, 1'b0, 4'd2,   0,  1'b1, 1'b0, 4'd0,  1'b1, 1};
    // Back-to-back loads after the mid-swap reset.
    vecs[8]  = '{1'b1, 1'b0, 4'd3,  -1,  1'b0, 1'b1, 4'd3,  1'b0, 3};
    vecs[9]  = '{1'b0, 1'b1, 4'd4,  -1,  1'b0, 1'b1, 4'd4,  1'b0, 4};
    vecs[10] = '{1'b1, 1'b0, 4'd2,  -1,  1'b1, 1'b0, 4'd2,  1'b0, 2};

    // Reset state, then idle with no load.
    #3;
    check("rst a_o", 32'(a_o), 32'd0);
    check("rst b_o", 32'(b_o), 32'd0);
    check("rst swap_cnt", 32'(swap_cnt), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_aborted", 32'(out_aborted), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst load_ready", 32'(load_ready), 32'd1);
    check("rst state", 32'(state_dbg), 32'(IDLE));
`ifdef SWAP_SCHED_STATS_EN
    check("rst swap_total", swap_total, 32'd0);
`endif
    #10 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle out_valid", 32'(out_valid), 32'd0);
      check("idle load_ready", 32'(load_ready), 32'd1);
      check("idle swap_cnt", 32'(swap_cnt), 32'd0);
      check("idle a_o", 32'(a_o), 32'd0);
    end

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Backpressure in DONE with load_valid held high.
    run_vec_hold : begin
      load_valid = 1'b1;
      a_i = 1'b1;
      b_i = 1'b0;
      cnt_i = 4'd1;
      tick();
      a_i = 1'b0;
      b_i = 1'b0;
      cnt_i = 4'd7;
      tick();
      exp_total += 1;
      for (int i = 0; i < 6; i++) begin
        check("bp out_valid", 32'(out_valid), 32'd1);
        check("bp load_ready", 32'(load_ready), 32'd0);
        check("bp a_o", 32'(a_o), 32'd0);
        check("bp b_o", 32'(b_o), 32'd1);
        check("bp swap_cnt", 32'(swap_cnt), 32'd1);
        tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      load_valid = 1'b0;
      check("bp release load_ready", 32'(load_ready), 32'd1);
      check("bp release out_valid", 32'(out_valid), 32'd0);
      check("bp release a_o", 32'(a_o), 32'd0);
    end

`ifdef SWAP_SCHED_STATS_EN
    check("total before reset", swap_total, 32'(exp_total));
`endif

    // Asynchronous reset in the middle of a 7-swap run.
    load_valid = 1'b1;
    a_i = 1'b1;
    b_i = 1'b0;
    cnt_i = 4'd7;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    tick();
    check("mid busy", 32'(busy), 32'd1);
    check("mid swap_cnt", 32'(swap_cnt), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst a_o", 32'(a_o), 32'd0);
    check("arst b_o", 32'(b_o), 32'd0);
    check("arst swap_cnt", 32'(swap_cnt), 32'd0);
    check("arst busy", 32'(busy), 32'd0);
    check("arst load_ready", 32'(load_ready), 32'd1);
    check("arst out_valid", 32'(out_valid), 32'd0);
`ifdef SWAP_SCHED_STATS_EN
    check("arst swap_total", swap_total, 32'd0);
`endif
    #2 rst_n = 1'b1;
    tick();
    exp_total = 0;
    for (int i = 8; i < 11; i++) run_vec(vecs[i], i);
`ifdef SWAP_SCHED_STATS_EN
    check("swap_total sum", swap_total, 32'(exp_total));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
